// File: rtl/pipelined_shifter_pkg.sv
// Shared types and helpers for the pipelined shift/rotate unit.
package pipelined_shifter_pkg;

  typedef enum logic [2:0] {
    SHIFT_SLL = 3'b000,
    SHIFT_SRL = 3'b001,
    SHIFT_SRA = 3'b010,
    SHIFT_ROL = 3'b011,
    SHIFT_ROR = 3'b100
  } mode_t;

  // Number of register stages for m mux layers grouped reg_every per stage.
  function automatic int calc_latency(input int m, input int reg_every);
    return (m + reg_every - 1) / reg_every;
  endfunction

  // Index of the last mux layer evaluated ahead of register stage s.
  function automatic int stage_last_layer(input int s, input int m, input int reg_every);
    return (((s + 1) * reg_every) < m) ? ((s + 1) * reg_every - 1) : (m - 1);
  endfunction

endpackage

// File: rtl/pipelined_shifter_layer.sv
// One combinational layer of the shifter: moves data by 2**K positions when en is set.
module shift_layer
  import pipelined_shifter_pkg::*;
#(
  parameter int N = 32,
  parameter int K = 0
) (
  input  logic [N-1:0] data,
  input  logic         en,
  input  logic [2:0]   mode,
  input  logic         sign,
  output logic [N-1:0] result
);

  localparam int S = 2 ** K;

  // Select the shifted/rotated form of data; unknown modes pass through.
  always_comb begin
    result = data;
    if (en) begin
      case (mode)
        SHIFT_SLL: result = {data[N-S-1:0], {S{1'b0}}};
        SHIFT_SRL: result = {{S{1'b0}}, data[N-1:S]};
        SHIFT_SRA: result = {{S{sign}}, data[N-1:S]};
        SHIFT_ROL: result = {data[N-S-1:0], data[N-1:N-S]};
        SHIFT_ROR: result = {data[S-1:0], data[N-1:S]};
        default:   result = data;
      endcase
    end else begin
      result = data;
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined shift/rotate unit with valid/ready handshake on both sides.
// Optional flag outputs (out_zero, out_carry) are enabled with PIPELINED_SHIFTER_FLAGS_EN.
module pipelined_shifter
  import pipelined_shifter_pkg::*;
#(
  parameter int N         = 32,
  parameter int M         = 5,
  parameter int REG_EVERY = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [M-1:0] in_shamt,
  input  logic [2:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
`ifdef PIPELINED_SHIFTER_FLAGS_EN
  ,
  output logic         out_zero,
  output logic         out_carry
`endif
);

  localparam int L = calc_latency(M, REG_EVERY);

  logic         advance_s;

  logic         valid_r [L];
  logic [N-1:0] data_r  [L];
  logic [2:0]   mode_r  [L];
  logic         sign_r  [L];
  logic [M-1:0] shamt_r [L];

  logic         src_valid_s [L];
  logic [N-1:0] src_data_s  [L];
  logic [2:0]   src_mode_s  [L];
  logic         src_sign_s  [L];
  logic [M-1:0] src_shamt_s [L];

  logic [N-1:0] layer_out_s   [M];
  logic [N-1:0] stage_res_s   [L];
  logic [M-1:0] stage_shamt_s [L];

  // The whole pipe moves in lockstep; only a stalled valid result blocks it.
  assign advance_s = !valid_r[L-1] || out_ready;
  assign in_ready  = advance_s;
  assign out_valid = valid_r[L-1];
  assign out_data  = data_r[L-1];

  genvar gs, gk;
  generate
    for (gs = 0; gs < L; gs++) begin : g_stage
      localparam int LAST = stage_last_layer(gs, M, REG_EVERY);
      if (gs == 0) begin : g_entry
        assign src_valid_s[gs] = in_valid;
        assign src_data_s[gs]  = in_data;
        assign src_mode_s[gs]  = in_mode;
        assign src_sign_s[gs]  = in_data[N-1];
        assign src_shamt_s[gs] = in_shamt;
      end else begin : g_inner
        assign src_valid_s[gs] = valid_r[gs-1];
        assign src_data_s[gs]  = data_r[gs-1];
        assign src_mode_s[gs]  = mode_r[gs-1];
        assign src_sign_s[gs]  = sign_r[gs-1];
        assign src_shamt_s[gs] = shamt_r[gs-1];
      end
      assign stage_res_s[gs]   = layer_out_s[LAST];
      // Bits already consumed by this stage's layers are dropped from the carried amount.
      assign stage_shamt_s[gs] = (src_shamt_s[gs] >> (LAST + 1)) << (LAST + 1);
    end

    for (gk = 0; gk < M; gk++) begin : g_layer
      localparam int ST = gk / REG_EVERY;
      logic [N-1:0] layer_in_s;
      if ((gk % REG_EVERY) == 0) begin : g_head
        assign layer_in_s = src_data_s[ST];
      end else begin : g_chain
        assign layer_in_s = layer_out_s[gk-1];
      end
      shift_layer #(
        .N (N),
        .K (gk)
      ) u_layer (
        .data   (layer_in_s),
        .en     (src_shamt_s[ST][gk]),
        .mode   (src_mode_s[ST]),
        .sign   (src_sign_s[ST]),
        .result (layer_out_s[gk])
      );
    end
  endgenerate

  // Pipeline stage registers: cleared on reset, all advance together or all hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < L; s++) begin
        valid_r[s] <= 1'b0;
        data_r[s]  <= {N{1'b0}};
        mode_r[s]  <= 3'b000;
        sign_r[s]  <= 1'b0;
        shamt_r[s] <= {M{1'b0}};
      end
    end else if (advance_s) begin
      for (int s = 0; s < L; s++) begin
        valid_r[s] <= src_valid_s[s];
        data_r[s]  <= stage_res_s[s];
        mode_r[s]  <= src_mode_s[s];
        sign_r[s]  <= src_sign_s[s];
        shamt_r[s] <= stage_shamt_s[s];
      end
    end
  end

`ifdef PIPELINED_SHIFTER_FLAGS_EN
  localparam logic [M-1:0] SHAMT_ONE = M'(1'b1);

  logic         entry_carry_s;
  logic [M-1:0] neg_shamt_s;
  logic         src_carry_s [L];
  logic         carry_r     [L];
  logic         zero_r;

  assign neg_shamt_s = {M{1'b0}} - in_shamt;

  // Last bit pushed out of the word, known up front from the operand and amount.
  always_comb begin
    entry_carry_s = 1'b0;
    if (in_shamt != {M{1'b0}}) begin
      case (in_mode)
        SHIFT_SLL:            entry_carry_s = in_data[neg_shamt_s];
        SHIFT_SRL, SHIFT_SRA: entry_carry_s = in_data[in_shamt - SHAMT_ONE];
        default:              entry_carry_s = 1'b0;
      endcase
    end else begin
      entry_carry_s = 1'b0;
    end
  end

  genvar gc;
  generate
    for (gc = 0; gc < L; gc++) begin : g_carry
      if (gc == 0) begin : g_entry
        assign src_carry_s[gc] = entry_carry_s;
      end else begin : g_inner
        assign src_carry_s[gc] = carry_r[gc-1];
      end
    end
  endgenerate

  // Flag registers travel with the data so they line up with out_data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < L; s++) begin
        carry_r[s] <= 1'b0;
      end
      zero_r <= 1'b0;
    end else if (advance_s) begin
      for (int s = 0; s < L; s++) begin
        carry_r[s] <= src_carry_s[s];
      end
      zero_r <= (stage_res_s[L-1] == {N{1'b0}});
    end
  end

  assign out_zero  = zero_r;
  assign out_carry = carry_r[L-1];
`else
  // Without flags the pipe carries only valid, data, mode, sign and shamt.
`endif

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed self-checking bench for pipelined_shifter (N=32, M=5, REG_EVERY=2).
module tb_pipelined_shifter;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [2:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef PIPELINED_SHIFTER_FLAGS_EN
  logic        out_zero;
  logic        out_carry;
`endif

  int checks = 0;
  int errors = 0;

  pipelined_shifter #(.N(32), .M(5), .REG_EVERY(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPELINED_SHIFTER_FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_carry (out_carry)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation, wait (bounded) for its result, check value and latency.
  task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] sh,
                        input logic [2:0] md, input logic [31:0] exp);
    int cyc;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh;
    in_mode  = md;
    @(negedge clock);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'd3);
    check(tag, out_data, exp);
  endtask

  initial begin
    int next_in;
    int next_out;
    logic [31:0] held;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_shamt  = 5'd0;
    in_mode   = 3'b000;
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;

    run_op("sll31", 32'h0000_0001, 5'd31, 3'b000, 32'h8000_0000);
    run_op("sra4",  32'h8000_0000, 5'd4,  3'b010, 32'hF800_0000);
    run_op("srl4",  32'h8000_0000, 5'd4,  3'b001, 32'h0800_0000);
    run_op("ror4",  32'h0000_000F, 5'd4,  3'b100, 32'hF000_0000);
    run_op("rol1",  32'h8000_0001, 5'd1,  3'b011, 32'h0000_0003);
    run_op("rol20", 32'h0000_0F01, 5'd20, 3'b011, 32'hF010_0000);
    run_op("sra17", 32'h4000_0000, 5'd17, 3'b010, 32'h0000_2000);

    for (int m = 0; m < 5; m++) begin
      run_op($sformatf("sh0_m%0d", m), 32'hDEAD_BEEF, 5'd0, 3'(m), 32'hDEAD_BEEF);
    end
    run_op("pass7", 32'hDEAD_BEEF, 5'd7, 3'b111, 32'hDEAD_BEEF);

`ifdef PIPELINED_SHIFTER_FLAGS_EN
    run_op("flag_sll", 32'hC000_0000, 5'd2, 3'b000, 32'h0000_0000);
    check("flag_sll_zero",  {31'd0, out_zero},  32'd1);
    check("flag_sll_carry", {31'd0, out_carry}, 32'd1);
    run_op("flag_srl", 32'h0000_0002, 5'd1, 3'b001, 32'h0000_0001);
    check("flag_srl_zero",  {31'd0, out_zero},  32'd0);
    check("flag_srl_carry", {31'd0, out_carry}, 32'd0);
`endif

    // Back-to-back: operand i is 1 shifted left by i; results one per cycle from cycle 3.
    for (int c = 0; c < 11; c++) begin
      @(negedge clock);
      if (c >= 3) begin
        check($sformatf("b2b_valid%0d", c), {31'd0, out_valid}, 32'd1);
        check($sformatf("b2b_data%0d", c), out_data, 32'h1 << (c - 3));
      end else begin
        check($sformatf("b2b_idle%0d", c), {31'd0, out_valid}, 32'd0);
      end
      if (c < 8) begin
        in_valid = 1'b1;
        in_data  = 32'h0000_0001;
        in_shamt = 5'(c);
        in_mode  = 3'b000;
      end else begin
        in_valid = 1'b0;
      end
    end

    // Backpressure: six pass-through operands, out_ready low for cycles 3..7.
    next_in  = 0;
    next_out = 0;
    held     = 32'h0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clock);
      out_ready = (c < 3 || c > 7);
      in_valid  = (next_in < 6);
      in_data   = 32'hA0 + 32'(next_in);
      in_shamt  = 5'd0;
      in_mode   = 3'b101;
      #1;
      if (c == 3) begin
        held = out_data;
        check("stall_valid3", {31'd0, out_valid}, 32'd1);
        check("stall_head", held, 32'hA0);
      end
      if (c >= 3 && c <= 7) begin
        check($sformatf("stall_in_ready%0d", c), {31'd0, in_ready}, 32'd0);
      end
      if (c > 3 && c <= 7) begin
        check($sformatf("stall_hold%0d", c), out_data, held);
      end
      if (out_valid && out_ready) begin
        check($sformatf("stall_ret%0d", next_out), out_data, 32'hA0 + 32'(next_out));
        next_out++;
      end
      if (in_valid && in_ready) begin
        next_in++;
      end
    end
    in_valid = 1'b0;
    check("stall_count", 32'(next_out), 32'd6);

    // Reset with three operations in flight.
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = 32'h1234_0000 + 32'(c);
      in_shamt = 5'd1;
      in_mode  = 3'b000;
    end
    @(negedge clock);
    in_valid = 1'b0;
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_data", out_data, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("postrst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      check($sformatf("postrst_idle%0d", c), {31'd0, out_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined shift/rotate unit for the ALU datapath.
- Supports five modes: SLL, SRL, SRA, ROL, ROR.
- Log-depth mux network with a pipeline register inserted after every REG_EVERY mux layers.
- Valid/ready handshake on input and output, so the unit can sit between the ALU operand stage and the writeback stage with backpressure.

Parameters:
- N, 32, data width; must be a power of two, >= 2.
- M, 5, shift-amount width; must equal log2(N).
- REG_EVERY, 2, mux layers per pipeline register; range 1..M.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  unit can accept an operand this cycle.
- in_data  in  N  operand.
- in_shamt  in  M  shift amount, 0..N-1.
- in_mode  in  3  operation: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101-111 pass-through (out = in).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  N  result.

Behaviour:
- Latency: L = ceil(M/REG_EVERY) cycles from input handshake to out_valid. The last register stage drives the out_* ports directly.
- Example: N=32, REG_EVERY=2 gives L=3.
- Layer k (k=0..M-1) shifts by 2**k when shamt[k]=1. Layers run LSB first.
- Fill rules:
  - SLL, SRL: fill with 0.
  - SRA: fill with in_data[N-1], captured at entry and carried down the pipe with the data.
  - ROL, ROR: wrap the vacated bits around.
- Each register stage holds: valid, data, mode, sign bit, and the still-unapplied shamt bits.
- Stall: advance = !out_valid || out_ready.
  - When advance=1, all stages shift forward together.
  - When advance=0, every stage holds.
  - Bubbles are not compressed.
- in_ready = advance, a combinational function of out_valid and out_ready.
- Input handshake occurs when in_valid && in_ready. If in_valid=0 while advancing, a bubble (valid=0) enters stage 0.
- Throughput is one result per cycle when out_ready is held high.
- Simultaneous out handshake and in handshake in the same cycle is legal. The pipeline advances, a new entry is taken, and the result is retired.
- shamt=0: out_data = in_data in every mode.
- Reset, including mid-operation: all valid bits go to 0 immediately, out_valid=0, out_data=0, and all internal data and shamt registers are cleared. In-flight operations are discarded. in_ready is 1 in the first cycle after reset deasserts.
- out_data and out_valid are stable while out_valid && !out_ready.

Optional Feature:
- Macro: PIPELINED_SHIFTER_FLAGS_EN.
- When defined, adds two outputs, both registered alongside out_data and with the same latency and reset value 0:
  - out_zero (1 bit): out_data == 0.
  - out_carry (1 bit): last bit shifted out. For SLL this is in_data[N-shamt]; for SRL and SRA it is in_data[shamt-1]. It is 0 for rotates, pass-through, or shamt=0.
- When undefined, neither port nor its logic exists.

Decomposition:
- Shared package pipelined_shifter_pkg holds:
  - the mode typedef (3-bit enum: SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROL, SHIFT_ROR);
  - a constant function for L from M and REG_EVERY.
- One natural sub-module: shift_layer. It is the combinational single-layer 2**k shifter, parametrised by N and the layer index K, with inputs data, en, mode, sign.
- The top module generates the M layers and the register stages.

Test Plan:
- N=32, REG_EVERY=2, out_ready=1: SLL 0x0000_0001 by 31 gives 0x8000_0000, with out_valid exactly 3 cycles after the input handshake.
- SRA 0x8000_0000 by 4 gives 0xF800_0000. SRL of the same operand gives 0x0800_0000. ROR 0x0000_000F by 4 gives 0xF000_0000. ROL 0x8000_0001 by 1 gives 0x0000_0003.
- Back-to-back 8 operands with out_ready=1: 8 results in consecutive cycles, in order. Then hold out_ready=0 for 5 cycles: in_ready=0, out_data stable, no results lost or duplicated after release.
- Assert reset for 1 cycle with 3 operations in flight: out_valid=0 at once, no stale result afterwards, in_ready=1 after reset deasserts.
- shamt=0 in all 5 modes, plus mode 3'b111 with shamt=7, on operand 0xDEAD_BEEF: out = 0xDEAD_BEEF in all cases.
- With PIPELINED_SHIFTER_FLAGS_EN defined:
  - SLL 0xC000_0000 by 2 gives out_data=0, out_zero=1, out_carry=1.
  - SRL 0x0000_0002 by 1 gives out_carry=0, out_zero=0.
